// File: rtl/amx_mac_array.sv
// ---------------------------------------------------------------------------
// amx_mac_array
//
// Multi-channel multiply-accumulate engine fed by a byte-wide operand stream.
// Operands arrive as A,B pairs.  Each pair is multiplied and the product is
// accumulated into one channel.  Channels are chosen round-robin.  The
// accumulators saturate and set sticky per-channel overflow flags.  They are
// read back as a serial byte dump: channel 0 first, least significant byte
// first.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_data      operand stream (DATA_W bits)
//   in_valid     operand present; accepted when in_valid && in_ready
//   in_ready     engine can accept an operand (states S_A / S_B)
//   signed_mode  1 = two's-complement arithmetic, 0 = unsigned
//   clear        single-cycle pulse: zero all state, return to S_A
//   dump         single-cycle pulse: start readout (honoured only in S_A)
//   out_data     dump byte
//   out_valid    out_data is valid this cycle
//   busy         high in S_MAC and S_DUMP
//   ovf          sticky per-channel saturation flags
// ---------------------------------------------------------------------------
module amx_mac_array #(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 4,
    parameter int ACC_W    = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                signed_mode,
    input  logic                clear,
    input  logic                dump,
    output logic [7:0]          out_data,
    output logic                out_valid,
    output logic                busy,
    output logic [CHANNELS-1:0] ovf
);

    localparam int NBYTES = (ACC_W + 7) / 8;
    localparam int DUMP_W = NBYTES * 8;
    localparam int CW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int PW     = 2 * DATA_W;
    // One guard bit above the accumulator is enough: both the unsigned and
    // the signed sum of an in-range accumulator and a product fit in ACC_W+1.
    localparam int SW     = ACC_W + 1;

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_MAC  = 2'd2,
        S_DUMP = 2'd3
    } state_t;

    state_t            state;
    logic [ACC_W-1:0]  acc [CHANNELS];
    logic [CW-1:0]     ptr;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;

    // Dump bookkeeping: the byte currently on out_data and the signedness
    // captured when the dump started.
    logic [CW-1:0]     cur_ch;
    logic [BW-1:0]     cur_byte;
    logic              dump_signed;

    // ------------------------------------------------------------------
    // Status decodes straight from the state register, so they follow an
    // asynchronous reset immediately.
    // ------------------------------------------------------------------
    assign in_ready = (state == S_A) || (state == S_B);
    assign busy     = (state == S_MAC) || (state == S_DUMP);

    // ------------------------------------------------------------------
    // Multiply-accumulate datapath with saturation.
    // ------------------------------------------------------------------
    logic [PW-1:0]    a_ext;
    logic [PW-1:0]    b_ext;
    logic [PW-1:0]    prod;
    logic [SW-1:0]    prod_ext;
    logic [SW-1:0]    acc_ext;
    logic [SW-1:0]    sum;
    logic [ACC_W-1:0] acc_cur;
    logic [ACC_W-1:0] mac_result;
    logic             mac_clamp;

    always_comb begin
        acc_cur  = acc[ptr];
        a_ext    = signed_mode ? {{DATA_W{a_reg[DATA_W-1]}}, a_reg}
                               : {{DATA_W{1'b0}}, a_reg};
        b_ext    = signed_mode ? {{DATA_W{b_reg[DATA_W-1]}}, b_reg}
                               : {{DATA_W{1'b0}}, b_reg};
        // A 2*DATA_W-bit product of extended operands is exact for both
        // signed and unsigned interpretations.
        prod     = a_ext * b_ext;
        prod_ext = signed_mode ? {{(SW-PW){prod[PW-1]}}, prod}
                               : {{(SW-PW){1'b0}}, prod};
        acc_ext  = signed_mode ? {acc_cur[ACC_W-1], acc_cur}
                               : {1'b0, acc_cur};
        sum        = acc_ext + prod_ext;
        mac_result = sum[ACC_W-1:0];
        mac_clamp  = 1'b0;
        if (signed_mode) begin
            // Guard bit disagreeing with the sign bit means the result left
            // the signed range; the guard bit tells which end to clamp to.
            if (sum[SW-1] != sum[SW-2]) begin
                mac_clamp  = 1'b1;
                mac_result = sum[SW-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                       : {1'b0, {(ACC_W-1){1'b1}}};
            end
        end else begin
            if (sum[SW-1]) begin
                mac_clamp  = 1'b1;
                mac_result = {ACC_W{1'b1}};
            end
        end
    end

    // ------------------------------------------------------------------
    // Dump byte selection.  The accumulator is widened to a whole number
    // of bytes, sign-extended only for a signed dump.
    // ------------------------------------------------------------------
    function automatic logic [7:0] pick_byte(input logic [ACC_W-1:0] val,
                                             input logic [BW-1:0]    idx,
                                             input logic             sgn);
        logic [DUMP_W-1:0] wide;
        wide              = {DUMP_W{sgn & val[ACC_W-1]}};
        wide[ACC_W-1:0]   = val;
        return wide[int'(idx)*8 +: 8];
    endfunction

    logic [CW-1:0] nxt_ch;
    logic [BW-1:0] nxt_byte;
    logic          dump_last;
    logic [7:0]    first_byte;
    logic [7:0]    next_byte;

    always_comb begin
        dump_last = (cur_ch == CW'(CHANNELS-1)) && (cur_byte == BW'(NBYTES-1));
        if (cur_byte == BW'(NBYTES-1)) begin
            nxt_byte = '0;
            nxt_ch   = cur_ch + 1'b1;
        end else begin
            nxt_byte = cur_byte + 1'b1;
            nxt_ch   = cur_ch;
        end
        first_byte = pick_byte(acc[0], '0, signed_mode);
        next_byte  = pick_byte(acc[nxt_ch], nxt_byte, dump_signed);
    end

    // ------------------------------------------------------------------
    // Control FSM and all state.  clear wins over everything, then dump,
    // then an offered operand.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_A;
            for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
            ovf         <= '0;
            ptr         <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            cur_ch      <= '0;
            cur_byte    <= '0;
            dump_signed <= 1'b0;
            out_data    <= '0;
            out_valid   <= 1'b0;
        end else if (clear) begin
            state     <= S_A;
            for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
            ovf       <= '0;
            ptr       <= '0;
            a_reg     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_A: begin
                    if (dump) begin
                        state       <= S_DUMP;
                        dump_signed <= signed_mode;
                        cur_ch      <= '0;
                        cur_byte    <= '0;
                        out_data    <= first_byte;
                        out_valid   <= 1'b1;
                    end else if (in_valid) begin
                        a_reg <= in_data;
                        state <= S_B;
                    end
                end
                S_B: begin
                    if (in_valid) begin
                        b_reg <= in_data;
                        state <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc[ptr] <= mac_result;
                    if (mac_clamp) ovf[ptr] <= 1'b1;
                    ptr   <= (ptr == CW'(CHANNELS-1)) ? '0 : ptr + 1'b1;
                    state <= S_A;
                end
                S_DUMP: begin
                    if (dump_last) begin
                        out_valid <= 1'b0;
                        out_data  <= '0;
                        state     <= S_A;
                    end else begin
                        cur_ch   <= nxt_ch;
                        cur_byte <= nxt_byte;
                        out_data <= next_byte;
                    end
                end
                default: state <= S_A;
            endcase
        end
    end

endmodule

// File: tb/tb_amx_mac_array.sv
// ---------------------------------------------------------------------------
// tb_amx_mac_array
//
// Directed self-checking bench for amx_mac_array with the default
// parameters (DATA_W=8, CHANNELS=4, ACC_W=20, 3 bytes per channel).
// Inputs change on the falling clock edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_amx_mac_array;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       signed_mode;
    logic       clear;
    logic       dump;
    logic [7:0] out_data;
    logic       out_valid;
    logic       busy;
    logic [3:0] ovf;

    int numChecks = 0;
    int failCount = 0;

    logic [7:0] dumpBytes [12];
    logic [7:0] expBytes  [12];

    amx_mac_array #(.DATA_W(8), .CHANNELS(4), .ACC_W(20)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .signed_mode (signed_mode),
        .clear       (clear),
        .dump        (dump),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .busy        (busy),
        .ovf         (ovf)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends on its own.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        numChecks++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Offer one operand for a single clock edge.
    task automatic sendByte(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Full A,B pair; checks the one-cycle MAC bubble after B.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
        sendByte(a);
        sendByte(b);
        checkOutput("ready_after_b", in_ready, 1'b0);
        checkOutput("busy_in_mac", busy, 1'b1);
        @(negedge clk);
    endtask

    task automatic pulseClear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    // Full 12-byte dump; every byte must be valid on consecutive cycles.
    task automatic doDump(input int testId);
        dump = 1'b1;
        @(negedge clk);
        dump = 1'b0;
        for (int i = 0; i < 12; i++) begin
            checkOutput($sformatf("t%0d_valid_b%0d", testId, i), out_valid, 1'b1);
            dumpBytes[i] = out_data;
            @(negedge clk);
        end
        checkOutput($sformatf("t%0d_valid_end", testId), out_valid, 1'b0);
        checkOutput($sformatf("t%0d_busy_end", testId), busy, 1'b0);
    endtask

    task automatic compareDump(input int testId);
        for (int i = 0; i < 12; i++)
            checkOutput($sformatf("t%0d_byte%0d", testId, i), dumpBytes[i], expBytes[i]);
    endtask

    task automatic setExpected(input logic [23:0] c0, input logic [23:0] c1,
                               input logic [23:0] c2, input logic [23:0] c3);
        logic [95:0] all;
        all = {c3, c2, c1, c0};
        for (int i = 0; i < 12; i++) expBytes[i] = all[i*8 +: 8];
    endtask

    initial begin
        rst_n       = 1'b0;
        in_data     = '0;
        in_valid    = 1'b0;
        signed_mode = 1'b0;
        clear       = 1'b0;
        dump        = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state.
        checkOutput("rst_in_ready", in_ready, 1'b1);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_out_data", out_data, 8'h00);
        checkOutput("rst_ovf", ovf, 4'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1: unsigned pairs, 3*5 = 15 into ch0, 10*20 = 200 into ch1.
        signed_mode = 1'b0;
        applyStimulus(8'h03, 8'h05);
        applyStimulus(8'h0A, 8'h14);
        checkOutput("t1_ptr", dut.ptr, 2);
        checkOutput("t1_ovf", ovf, 4'h0);
        doDump(1);
        setExpected(24'h00000F, 24'h0000C8, 24'h000000, 24'h000000);
        compareDump(1);

        // Test 2: signed -2 * 7 = -14 into ch0, sign-extended dump.
        pulseClear();
        signed_mode = 1'b1;
        applyStimulus(8'hFE, 8'h07);
        checkOutput("t2_ovf", ovf, 4'h0);
        doDump(2);
        setExpected(24'hFFFFF2, 24'h000000, 24'h000000, 24'h000000);
        compareDump(2);

        // Test 3: 0xFF*0xFF = 65025; 16 per channel = 1040400 still fits,
        // the 17th exceeds 2^20-1 and saturates every channel.
        pulseClear();
        signed_mode = 1'b0;
        for (int i = 0; i < 64; i++) applyStimulus(8'hFF, 8'hFF);
        checkOutput("t3_ovf_before", ovf, 4'h0);
        for (int i = 0; i < 4; i++) applyStimulus(8'hFF, 8'hFF);
        checkOutput("t3_ovf_after", ovf, 4'hF);
        doDump(3);
        setExpected(24'h0FFFFF, 24'h0FFFFF, 24'h0FFFFF, 24'h0FFFFF);
        compareDump(3);
        checkOutput("t3_ovf_sticky", ovf, 4'hF);

        // Test 4: held A discarded by clear.
        pulseClear();
        checkOutput("t4_ovf_cleared", ovf, 4'h0);
        sendByte(8'h09);
        pulseClear();
        applyStimulus(8'h02, 8'h03);
        checkOutput("t4_ptr", dut.ptr, 1);
        doDump(4);
        setExpected(24'h000006, 24'h000000, 24'h000000, 24'h000000);
        compareDump(4);

        // Test 5a: dump in S_B is ignored.
        pulseClear();
        sendByte(8'h04);
        dump = 1'b1;
        @(negedge clk);
        dump = 1'b0;
        checkOutput("t5_dump_in_b_valid", out_valid, 1'b0);
        checkOutput("t5_dump_in_b_busy", busy, 1'b0);
        checkOutput("t5_dump_in_b_ready", in_ready, 1'b1);
        sendByte(8'h03);
        checkOutput("t5_mac_valid", out_valid, 1'b0);
        @(negedge clk);
        checkOutput("t5_after_mac_valid", out_valid, 1'b0);

        // Test 5b: byte offered with clear is not accepted.
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        applyStimulus(8'h02, 8'h05);
        doDump(5);
        setExpected(24'h00000A, 24'h000000, 24'h000000, 24'h000000);
        compareDump(5);

        // Test 6: reset in the middle of a dump.
        pulseClear();
        applyStimulus(8'h01, 8'h01);
        applyStimulus(8'h10, 8'h20);
        dump = 1'b1;
        @(negedge clk);
        dump = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("t6_byte4_valid", out_valid, 1'b1);
        checkOutput("t6_byte4_data", out_data, 8'h02);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_valid", out_valid, 1'b0);
        checkOutput("t6_rst_busy", busy, 1'b0);
        checkOutput("t6_rst_data", out_data, 8'h00);
        checkOutput("t6_rst_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        doDump(6);
        setExpected(24'h000000, 24'h000000, 24'h000000, 24'h000000);
        compareDump(6);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, failCount);
        $finish;
    end

endmodule
